// File: rtl/lcd_pkg.sv
// ---------------------------------------------------------------------------
// lcd_pkg
// Definitions shared by the LCD text formatter and the LCD command-queue
// logic: the 9-bit LCD word encodings, the control characters the formatter
// interprets, and the formatter FSM state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package lcd_pkg;

    // LCD words are {rs, data[7:0]}. rs=0 is a command, rs=1 a data write.
    localparam logic [8:0] LCD_CMD_CLEAR = 9'h001;
    localparam logic [8:0] LCD_CMD_DDRAM = 9'h080;  // OR in a 7-bit address
    localparam logic       LCD_RS_DATA   = 1'b1;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_TILDE = 8'h7E;   // last printable character

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Set-DDRAM-address command word for a 7-bit address.
    function automatic logic [8:0] ddram_cmd(input logic [6:0] addr);
        return LCD_CMD_DDRAM | {2'b00, addr};
    endfunction

endpackage

// File: rtl/lcd_text_formatter_if.sv
// ---------------------------------------------------------------------------
// lcd_text_formatter_if
// Bundles the two valid/ready channels of the formatter.
//   in_valid/in_char/in_ready    : character channel from the CPU write path
//   out_valid/out_cmd/out_ready  : LCD word channel toward the command queue
// Handshake rule (both channels): a word moves on a rising clock edge where
// valid and ready are both high; while valid is high and ready is low the
// producer holds valid and the payload stable.
// Modports: slave = formatter side, master = environment side.
// ---------------------------------------------------------------------------
interface lcd_text_formatter_if;
    logic       in_valid;
    logic [7:0] in_char;
    logic       in_ready;
    logic       out_valid;
    logic [8:0] out_cmd;
    logic       out_ready;

    modport slave (
        input  in_valid, in_char, out_ready,
        output in_ready, out_valid, out_cmd
    );

    modport master (
        output in_valid, in_char, out_ready,
        input  in_ready, out_valid, out_cmd
    );
endinterface

// File: rtl/lcd_text_formatter.sv
// ---------------------------------------------------------------------------
// lcd_text_formatter
// Turns a stream of ASCII bytes into LCD words for a 2-line display, handling
// line wrap, newline, carriage return, backspace and form feed.
// Ports:
//   clk        system clock
//   rst        synchronous, active-high reset
//   bus        lcd_text_formatter_if.slave (character in, LCD word out)
//   row        current cursor line
//   col        current cursor column (0..COLS)
//   busy       multi-word sequence in progress (= !in_ready)
//   dbg_state  FSM state, for observation only
// Each accepted byte is decoded into a sequence of up to 3 words which the
// EMIT state walks one word per two cycles. The cursor is updated at accept.
// ---------------------------------------------------------------------------
module lcd_text_formatter
    import lcd_pkg::*;
#(
    parameter int         COLS       = 16,
    parameter logic [6:0] LINE0_ADDR = 7'h00,
    parameter logic [6:0] LINE1_ADDR = 7'h40
) (
    input  logic                 clk,
    input  logic                 rst,
    lcd_text_formatter_if.slave  bus,
    output logic                 row,
    output logic [4:0]           col,
    output logic                 busy,
    output state_t               dbg_state
);

    localparam logic [4:0] COLS_W = 5'(COLS);

    state_t          state_q, state_d;
    logic [2:0][8:0] seq_q, seq_d;
    logic [1:0]      idx_q, idx_d;
    logic [1:0]      len_q, len_d;
    logic            row_q, row_d;
    logic [4:0]      col_q, col_d;
    logic            out_valid_q, out_valid_d;
    logic [8:0]      out_cmd_q, out_cmd_d;

    logic            in_ready;
    logic            accept;

    // Decoded result for the byte currently on in_char.
    logic [2:0][8:0] dec_seq;
    logic [1:0]      dec_len;
    logic            dec_row;
    logic [4:0]      dec_col;

    function automatic logic [8:0] addr_cmd(input logic r, input logic [4:0] c);
        return ddram_cmd((r ? LINE1_ADDR : LINE0_ADDR) + {2'b00, c});
    endfunction

    assign in_ready = (state_q == IDLE) && !out_valid_q;
    assign accept   = bus.in_valid && in_ready;

    // Byte decode: word sequence plus the cursor position after it.
    always_comb begin
        dec_seq = '0;
        dec_len = 2'd0;
        dec_row = row_q;
        dec_col = col_q;
        if (bus.in_char >= CH_SPACE && bus.in_char <= CH_TILDE) begin
            // Wrap is deferred: a full line only wraps when the next
            // printable byte arrives.
            if (col_q < COLS_W) begin
                dec_seq[0] = {LCD_RS_DATA, bus.in_char};
                dec_len    = 2'd1;
                dec_col    = col_q + 5'd1;
            end else if (!row_q) begin
                dec_seq[0] = addr_cmd(1'b1, 5'd0);
                dec_seq[1] = {LCD_RS_DATA, bus.in_char};
                dec_len    = 2'd2;
                dec_row    = 1'b1;
                dec_col    = 5'd1;
            end else begin
                dec_seq[0] = LCD_CMD_CLEAR;
                dec_seq[1] = addr_cmd(1'b0, 5'd0);
                dec_seq[2] = {LCD_RS_DATA, bus.in_char};
                dec_len    = 2'd3;
                dec_row    = 1'b0;
                dec_col    = 5'd1;
            end
        end else begin
            case (bus.in_char)
                CH_LF: begin
                    if (!row_q) begin
                        dec_seq[0] = addr_cmd(1'b1, 5'd0);
                        dec_len    = 2'd1;
                        dec_row    = 1'b1;
                    end else begin
                        dec_seq[0] = LCD_CMD_CLEAR;
                        dec_seq[1] = addr_cmd(1'b0, 5'd0);
                        dec_len    = 2'd2;
                        dec_row    = 1'b0;
                    end
                    dec_col = 5'd0;
                end
                CH_CR: begin
                    dec_seq[0] = addr_cmd(row_q, 5'd0);
                    dec_len    = 2'd1;
                    dec_col    = 5'd0;
                end
                CH_BS: begin
                    // Step back, blank the cell, and leave the cursor on it.
                    if (col_q != 5'd0) begin
                        dec_seq[0] = addr_cmd(row_q, col_q - 5'd1);
                        dec_seq[1] = {LCD_RS_DATA, CH_SPACE};
                        dec_seq[2] = addr_cmd(row_q, col_q - 5'd1);
                        dec_len    = 2'd3;
                        dec_col    = col_q - 5'd1;
                    end
                end
                CH_FF: begin
                    dec_seq[0] = LCD_CMD_CLEAR;
                    dec_seq[1] = addr_cmd(1'b0, 5'd0);
                    dec_len    = 2'd2;
                    dec_row    = 1'b0;
                    dec_col    = 5'd0;
                end
                default: begin
                    // Other bytes are swallowed without output.
                end
            endcase
        end
    end

    // Next-state logic. In EMIT, out_valid drops for one cycle after each
    // transfer and the following word is presented in that gap cycle.
    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        idx_d       = idx_q;
        len_d       = len_q;
        row_d       = row_q;
        col_d       = col_q;
        out_valid_d = out_valid_q;
        out_cmd_d   = out_cmd_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    seq_d = dec_seq;
                    len_d = dec_len;
                    idx_d = 2'd0;
                    row_d = dec_row;
                    col_d = dec_col;
                    if (dec_len != 2'd0) begin
                        state_d     = EMIT;
                        out_valid_d = 1'b1;
                        out_cmd_d   = dec_seq[0];
                    end
                end
            end
            EMIT: begin
                if (out_valid_q) begin
                    if (bus.out_ready) begin
                        out_valid_d = 1'b0;
                        if (idx_q == len_q - 2'd1) begin
                            state_d = IDLE;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end
                end else begin
                    out_valid_d = 1'b1;
                    out_cmd_d   = seq_q[idx_q];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            seq_q       <= '0;
            idx_q       <= 2'd0;
            len_q       <= 2'd0;
            row_q       <= 1'b0;
            col_q       <= 5'd0;
            out_valid_q <= 1'b0;
            out_cmd_q   <= 9'd0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            row_q       <= row_d;
            col_q       <= col_d;
            out_valid_q <= out_valid_d;
            out_cmd_q   <= out_cmd_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_cmd   = out_cmd_q;
    assign row           = row_q;
    assign col           = col_q;
    assign busy          = !in_ready;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_lcd_text_formatter.sv
// ---------------------------------------------------------------------------
// tb_lcd_text_formatter
// Self-checking bench for lcd_text_formatter: directed cases followed by a
// randomized character stream with random output backpressure. Expected LCD
// words come from a cursor model of the display kept in exp_q.
// ---------------------------------------------------------------------------
module tb_lcd_text_formatter;
    import lcd_pkg::*;

    localparam int COLS = 16;

    logic       clk;
    logic       rst;
    logic       row_w;
    logic [4:0] col_w;
    logic       busy_w;
    state_t     state_w;

    lcd_text_formatter_if bus ();

    lcd_text_formatter #(
        .COLS       (COLS),
        .LINE0_ADDR (7'h00),
        .LINE1_ADDR (7'h40)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .row       (row_w),
        .col       (col_w),
        .busy      (busy_w),
        .dbg_state (state_w)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard ----------------
    logic [8:0] exp_q[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         m_row = 0;
    int         m_col = 0;
    int         rdy_mode = 0;   // 0 random, 1 always ready, 2 stalled

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] m_addr(input int r, input int c);
        return 9'(32'h80 + (r != 0 ? 32'h40 : 32'h0) + c);
    endfunction

    // Display model: what the LCD must receive for one byte, and where the
    // cursor ends up.
    function automatic void model_char(input logic [7:0] ch);
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            if (m_col == COLS) begin
                if (m_row == 0) begin
                    exp_q.push_back(m_addr(1, 0));
                    m_row = 1;
                end else begin
                    exp_q.push_back(9'h001);
                    exp_q.push_back(m_addr(0, 0));
                    m_row = 0;
                end
                m_col = 0;
            end
            exp_q.push_back({1'b1, ch});
            m_col = m_col + 1;
        end else if (ch == 8'h0A) begin
            if (m_row == 0) begin
                exp_q.push_back(m_addr(1, 0));
                m_row = 1;
            end else begin
                exp_q.push_back(9'h001);
                exp_q.push_back(m_addr(0, 0));
                m_row = 0;
            end
            m_col = 0;
        end else if (ch == 8'h0D) begin
            exp_q.push_back(m_addr(m_row, 0));
            m_col = 0;
        end else if (ch == 8'h08) begin
            if (m_col > 0) begin
                m_col = m_col - 1;
                exp_q.push_back(m_addr(m_row, m_col));
                exp_q.push_back(9'h120);
                exp_q.push_back(m_addr(m_row, m_col));
            end
        end else if (ch == 8'h0C) begin
            exp_q.push_back(9'h001);
            exp_q.push_back(m_addr(0, 0));
            m_row = 0;
            m_col = 0;
        end
    endfunction

    // Output-side driver and monitor: chooses out_ready each cycle and, for
    // every word that will transfer on the next edge, checks it in order.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       bus.out_ready = ($urandom_range(0, 3) != 0);
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'b0;
            endcase
            if (!rst && bus.out_valid === 1'b1 && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", {23'd0, bus.out_cmd}, 32'h0000_0200);
                end else begin
                    chk("out_cmd", {23'd0, bus.out_cmd}, {23'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic check_cursor(input string tag);
        chk({tag, "_row"}, {31'd0, row_w}, 32'(m_row));
        chk({tag, "_col"}, {27'd0, col_w}, 32'(m_col));
        chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_row = 0;
        m_col = 0;
    endtask

    task automatic send_char(input logic [7:0] ch);
        @(negedge clk);
        wait_ready("in_ready_timeout");
        bus.in_valid = 1'b1;
        bus.in_char  = ch;
        model_char(ch);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_ready("sequence_timeout");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_char  = 8'h00;
        rdy_mode     = 1;

        do_reset();
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_cmd", {23'd0, bus.out_cmd}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy_w}, 32'd0);
        chk("rst_state", {31'd0, state_w}, {31'd0, IDLE});
        check_cursor("rst");

        // Single printable character.
        send_char(8'h41);
        check_cursor("one_char");
        chk("one_char_ready", {31'd0, bus.in_ready}, 32'd1);

        // Seventeen characters: deferred wrap onto line 1.
        do_reset();
        for (int i = 0; i < 17; i++) send_char(8'h41);
        check_cursor("wrap_l0");

        // Fill line 1 then wrap back to a cleared display.
        for (int i = 0; i < 15; i++) send_char(8'h41);
        check_cursor("full_l1");
        send_char(8'h42);
        check_cursor("wrap_l1");

        // Newline from line 1.
        send_char(8'h0A);
        for (int i = 0; i < 3; i++) send_char(8'h43);
        send_char(8'h0A);
        check_cursor("lf_l1");

        // Backspace mid-line, carriage return, backspace at column 0.
        for (int i = 0; i < 5; i++) send_char(8'h44);
        send_char(8'h08);
        check_cursor("bs");
        send_char(8'h0D);
        check_cursor("cr");
        send_char(8'h08);
        chk("bs_col0_ready", {31'd0, bus.in_ready}, 32'd1);
        check_cursor("bs_col0");

        // Dropped bytes.
        send_char(8'h45);
        send_char(8'h07);
        send_char(8'hC3);
        check_cursor("drop");

        // Backpressure: form feed with the queue stalled.
        rdy_mode = 2;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_char  = 8'h0C;
        model_char(8'h0C);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            chk("stall_cmd", {23'd0, bus.out_cmd}, 32'h001);
            chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
            @(negedge clk);
        end
        chk("stall_state", {31'd0, state_w}, {31'd0, EMIT});
        rdy_mode = 1;
        wait_ready("stall_release_timeout");
        check_cursor("ff");

        // Reset in the middle of a sequence.
        send_char(8'h46);
        send_char(8'h47);
        rdy_mode = 2;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_char  = 8'h0C;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_row = 0;
        m_col = 0;
        chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check_cursor("midrst");

        // Randomized stream with random backpressure.
        rdy_mode = 0;
        for (int i = 0; i < 400; i++) begin
            int         r;
            logic [7:0] ch;
            r = $urandom_range(0, 99);
            if (r < 70)      ch = 8'($urandom_range(32, 126));
            else if (r < 78) ch = 8'h0A;
            else if (r < 84) ch = 8'h0D;
            else if (r < 92) ch = 8'h08;
            else if (r < 95) ch = 8'h0C;
            else             ch = 8'($urandom_range(0, 255));
            send_char(ch);
            if (i % 16 == 15) check_cursor("rand");
        end
        check_cursor("rand_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
